// File: rtl/icache_direct.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// Hits answer one cycle after the request; misses fill a whole line, then answer.
module icache_direct #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IF_pc_sgn,
  input  logic [31:0] IF_pc,
  input  logic        IF_clr,
  output logic        IF_ins_sgn,
  output logic [31:0] IF_ins,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_data_sgn,
  input  logic [31:0] MC_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int IDX_LO   = WORD_BITS + 2;
  localparam int TAG_LO   = INDEX_BITS + WORD_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LO;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  logic                  valid_q [LINES];
  logic [TAG_BITS-1:0]   tag_q   [LINES];
  logic [31:0]           data_q  [LINES][WORDS];

  state_t                state_q, state_d;
  logic                  cancel_q, cancel_d;
  logic [31:0]           pc_q, pc_d;
  logic [WORD_BITS-1:0]  cnt_q, cnt_d;
  logic                  ins_sgn_q, ins_sgn_d;
  logic [31:0]           ins_q, ins_d;
  logic                  req_q, req_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           buf_q [WORDS];
  logic [31:0]           buf_d [WORDS];
  logic                  install;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [WORD_BITS-1:0]  req_off, fill_off;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;
  logic                  unused_bits;

  assign req_idx  = IF_pc[TAG_LO-1:IDX_LO];
  assign req_off  = IF_pc[IDX_LO-1:2];
  assign req_tag  = IF_pc[31:TAG_LO];
  assign fill_idx = pc_q[TAG_LO-1:IDX_LO];
  assign fill_off = pc_q[IDX_LO-1:2];
  assign fill_tag = pc_q[31:TAG_LO];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_bits = ^{IF_pc[1:0], pc_q[1:0]};

  always_comb begin
    state_d   = state_q;
    cancel_d  = cancel_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    ins_sgn_d = 1'b0;
    ins_d     = ins_q;
    req_d     = req_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    install   = 1'b0;
    case (state_q)
      IDLE: begin
        if (IF_pc_sgn && !IF_clr) begin
          if (hit) begin
            ins_sgn_d = 1'b1;
            ins_d     = data_q[req_idx][req_off];
          end else begin
            pc_d     = IF_pc;
            addr_d   = {IF_pc[31:IDX_LO], {IDX_LO{1'b0}}};
            req_d    = 1'b1;
            cnt_d    = '0;
            cancel_d = 1'b0;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        if (IF_clr) cancel_d = 1'b1;
        if (MC_data_sgn) begin
          buf_d[cnt_q] = MC_data;
          cnt_d        = cnt_q + WORD_BITS'(1);
          // The final word completes the line; the requested word may be this one
          if (cnt_q == WORD_BITS'(WORDS - 1)) begin
            install = 1'b1;
            req_d   = 1'b0;
            state_d = IDLE;
            if (!cancel_q && !IF_clr) begin
              ins_sgn_d = 1'b1;
              ins_d     = (fill_off == WORD_BITS'(WORDS - 1)) ? MC_data : buf_q[fill_off];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cancel_q  <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
      ins_sgn_q <= 1'b0;
      ins_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      for (int i = 0; i < WORDS; i++) buf_q[i] <= '0;
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      cancel_q  <= cancel_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      ins_sgn_q <= ins_sgn_d;
      ins_q     <= ins_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      if (install) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (!rst && rdy && install) begin
      tag_q[fill_idx] <= fill_tag;
      for (int w = 0; w < WORDS; w++) data_q[fill_idx][w] <= buf_d[w];
    end
  end

  assign IF_ins_sgn = ins_sgn_q;
  assign IF_ins     = ins_q;
  assign MC_req     = req_q;
  assign MC_addr    = addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct: fills, hits, conflicts,
// redirect cancel, rdy stall and reset during a fill.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        IF_pc_sgn;
  logic [31:0] IF_pc;
  logic        IF_clr;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_data_sgn;
  logic [31:0] MC_data;

  int tests;
  int fails;

  logic [31:0] line0 [4];
  logic [31:0] line400 [4];
  logic [31:0] line1000 [4];

  icache_direct dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IF_pc_sgn(IF_pc_sgn), .IF_pc(IF_pc), .IF_clr(IF_clr),
    .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins),
    .MC_req(MC_req), .MC_addr(MC_addr),
    .MC_data_sgn(MC_data_sgn), .MC_data(MC_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let a rising edge pass and settle
  task automatic applyStimulus(input logic pc_sgn, input logic [31:0] pc, input logic clr,
                               input logic dsgn, input logic [31:0] data);
    IF_pc_sgn   = pc_sgn;
    IF_pc       = pc;
    IF_clr      = clr;
    MC_data_sgn = dsgn;
    MC_data     = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    line0[0] = 32'h00000013; line0[1] = 32'h00100093;
    line0[2] = 32'h00200113; line0[3] = 32'h00300193;
    for (int i = 0; i < 4; i++) begin
      line400[i]  = 32'hA000_0000 + 32'(i);
      line1000[i] = 32'hB000_0000 + 32'(i);
    end
    rst = 1'b1;
    rdy = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("reset_ins_sgn", 32'(IF_ins_sgn), 0);
    checkOutput("reset_ins", IF_ins, 0);
    checkOutput("reset_req", 32'(MC_req), 0);
    checkOutput("reset_addr", MC_addr, 0);

    // 1: cold miss at 0x0, words with one-cycle gaps
    applyStimulus(1, 32'h0, 0, 0, 0);
    checkOutput("t1_req", 32'(MC_req), 1);
    checkOutput("t1_addr", MC_addr, 32'h0);
    checkOutput("t1_no_resp", 32'(IF_ins_sgn), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, line0[i]);
      if (i < 3) begin
        checkOutput("t1_fill_quiet", 32'(IF_ins_sgn), 0);
        applyStimulus(0, 0, 0, 0, 32'hDEADBEEF);
      end
    end
    checkOutput("t1_resp_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t1_resp_ins", IF_ins, 32'h00000013);
    checkOutput("t1_req_drop", 32'(MC_req), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_pulse_end", 32'(IF_ins_sgn), 0);

    // 2: hits, including back-to-back
    applyStimulus(1, 32'h8, 0, 0, 0);
    checkOutput("t2_hit_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t2_hit_ins", IF_ins, 32'h00200113);
    checkOutput("t2_hit_noreq", 32'(MC_req), 0);
    applyStimulus(1, 32'h0, 0, 0, 0);
    checkOutput("t2_b2b0_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t2_b2b0_ins", IF_ins, 32'h00000013);
    applyStimulus(1, 32'h4, 0, 0, 0);
    checkOutput("t2_b2b1_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t2_b2b1_ins", IF_ins, 32'h00100093);
    applyStimulus(1, 32'hC, 0, 0, 0);
    checkOutput("t2_b2b2_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t2_b2b2_ins", IF_ins, 32'h00300193);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_idle", 32'(IF_ins_sgn), 0);

    // 3: conflict on index 0
    applyStimulus(1, 32'h400, 0, 0, 0);
    checkOutput("t3_req", 32'(MC_req), 1);
    checkOutput("t3_addr", MC_addr, 32'h400);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, line400[i]);
    checkOutput("t3_resp_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t3_resp_ins", IF_ins, 32'hA0000000);
    applyStimulus(1, 32'h0, 0, 0, 0);
    checkOutput("t3_remiss_req", 32'(MC_req), 1);
    checkOutput("t3_remiss_addr", MC_addr, 32'h0);
    checkOutput("t3_remiss_nosgn", 32'(IF_ins_sgn), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, line0[i]);
    checkOutput("t3_refill_ins", IF_ins, 32'h00000013);

    // 4: redirect during the second fill word suppresses the response
    applyStimulus(1, 32'h1004, 0, 0, 0);
    checkOutput("t4_addr", MC_addr, 32'h1000);
    applyStimulus(0, 0, 0, 1, line1000[0]);
    applyStimulus(0, 0, 1, 1, line1000[1]);
    applyStimulus(0, 0, 0, 1, line1000[2]);
    applyStimulus(0, 0, 0, 1, line1000[3]);
    checkOutput("t4_cancel_nosgn", 32'(IF_ins_sgn), 0);
    checkOutput("t4_req_drop", 32'(MC_req), 0);
    applyStimulus(1, 32'h1004, 0, 0, 0);
    checkOutput("t4_hit_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t4_hit_ins", IF_ins, 32'hB0000001);
    checkOutput("t4_hit_noreq", 32'(MC_req), 0);

    // 5: rdy stall mid-fill with data presented
    applyStimulus(1, 32'h8, 0, 0, 0);
    checkOutput("t5_req", 32'(MC_req), 1);
    applyStimulus(0, 0, 0, 1, line0[0]);
    applyStimulus(0, 0, 0, 1, line0[1]);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'hBAD0_0000 + 32'(i));
      checkOutput("t5_stall_req", 32'(MC_req), 1);
      checkOutput("t5_stall_addr", MC_addr, 32'h0);
    end
    rdy = 1'b1;
    applyStimulus(0, 0, 0, 1, line0[2]);
    checkOutput("t5_not_done", 32'(MC_req), 1);
    checkOutput("t5_not_done_sgn", 32'(IF_ins_sgn), 0);
    applyStimulus(0, 0, 0, 1, line0[3]);
    checkOutput("t5_resp_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t5_resp_ins", IF_ins, 32'h00200113);
    checkOutput("t5_req_drop", 32'(MC_req), 0);
    rdy = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_hold_sgn", 32'(IF_ins_sgn), 1);
    rdy = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_sgn_clear", 32'(IF_ins_sgn), 0);

    // 6: reset mid-fill clears everything
    applyStimulus(1, 32'h2000, 0, 0, 0);
    checkOutput("t6_addr", MC_addr, 32'h2000);
    applyStimulus(0, 0, 0, 1, 32'hC0000000);
    applyStimulus(0, 0, 0, 1, 32'hC0000001);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("t6_rst_req", 32'(MC_req), 0);
    checkOutput("t6_rst_sgn", 32'(IF_ins_sgn), 0);
    checkOutput("t6_rst_addr", MC_addr, 0);
    applyStimulus(1, 32'h0, 0, 0, 0);
    checkOutput("t6_miss_req", 32'(MC_req), 1);
    checkOutput("t6_miss_nosgn", 32'(IF_ins_sgn), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, line0[i]);
    checkOutput("t6_refill_sgn", 32'(IF_ins_sgn), 1);
    checkOutput("t6_refill_ins", IF_ins, 32'h00000013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
